mips_multicycle_control: RTL and testbench

Main control state machine of the multicycle MIPS datapath. It decodes the 6-bit opcode from the instruction register and sequences every instruction through fetch, decode, execute, memory and writeback. Its `pc_src` output drives the select of the PC-source mux that feeds the PC: 0 selects the live ALU result (PC+4), 1 selects the registered ALUOut (branch target). It also produces the PC write enable, a memory handshake stall, an illegal-opcode pulse and a retired-instruction counter.

---
 rtl/mips_multicycle_control.sv | 205 ++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
//   Main control FSM of the multicycle MIPS datapath. It decodes the opcode
//   held in the instruction register and steps each instruction through
//   fetch, decode, execute, memory and writeback. It also drives the PC
//   enable, reports illegal opcodes and counts retired instructions.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   opcode[5:0]     instr[31:26] from the instruction register
//   zero            ALU zero flag, used for the BEQ decision
//   mem_ready       memory completes the current access this cycle
//   pc_en           PC load enable (unconditional write or taken branch)
//   pc_src          PC mux select: 0 = ALU result, 1 = ALUOut
//   jump_sel        PC takes the jump target, overriding pc_src
//   iord            memory address: 0 = PC, 1 = ALUOut
//   mem_read/write  memory strobes
//   ir_write        instruction register load
//   reg_write       register file write
//   reg_dst         write register: 0 = rt, 1 = rd
//   mem_to_reg      writeback data: 0 = ALUOut, 1 = MDR
//   alu_src_a       ALU A operand: 0 = PC, 1 = register A
//   alu_src_b[1:0]  ALU B operand: 00 = B, 01 = 4, 10 = imm, 11 = imm<<2
//   alu_op[1:0]     00 = add, 01 = subtract, 10 = decode funct
//   illegal_op      one-cycle pulse when DECODE sees an unknown opcode
//   retired_count   number of completed instructions (wraps)
//   state[3:0]      current state encoding, for debug
module mips_multicycle_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        pc_src,
  output logic        jump_sel,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        illegal_op,
  output logic [31:0] retired_count,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t state_q;
  state_t state_d;
  logic   pc_write;
  logic   pc_write_cond;
  logic   retire;

  // State register; reset drops straight back to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Retired-instruction counter, stepped on the final cycle of each
  // instruction. Abandoned (reset) and illegal instructions never count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count <= 32'd0;
    end else if (retire) begin
      retired_count <= retired_count + 32'd1;
    end
  end

  // Next-state and output decode. Everything is held at 0 while reset is
  // asserted so no strobe escapes even though the state already reads FETCH.
  always_comb begin
    state_d       = ST_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    jump_sel      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    illegal_op    = 1'b0;
    retire        = 1'b0;

    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          state_d   = mem_ready ? ST_DECODE : ST_FETCH;
        end
        // The branch target is computed here so BRANCH can load it from ALUOut.
        ST_DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            OP_LW, OP_SW: state_d = ST_MEMADR;
            OP_R:         state_d = ST_EXEC;
            OP_BEQ:       state_d = ST_BRANCH;
            OP_J:         state_d = ST_JUMP;
            OP_ADDI:      state_d = ST_ADDIEX;
            default: begin
              state_d    = ST_FETCH;
              illegal_op = 1'b1;
            end
          endcase
        end
        ST_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
        end
        ST_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          state_d  = mem_ready ? ST_MEMWB : ST_MEMRD;
        end
        ST_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
        end
        ST_MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          retire    = mem_ready;
          state_d   = mem_ready ? ST_FETCH : ST_MEMWR;
        end
        ST_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          state_d   = ST_ALUWB;
        end
        ST_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          retire    = 1'b1;
        end
        ST_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_src        = 1'b1;
          retire        = 1'b1;
        end
        ST_JUMP: begin
          pc_write = 1'b1;
          jump_sel = 1'b1;
          retire   = 1'b1;
        end
        ST_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = ST_ADDIWB;
        end
        ST_ADDIWB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  assign pc_en = pc_write | (pc_write_cond & zero);
  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control
//   Directed bench for the multicycle MIPS control FSM. Inputs change and
//   outputs are observed 1 ns after each falling edge; the state advances on
//   the rising edge in between.
module tb_mips_multicycle_control;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_en;
  logic        pc_src;
  logic        jump_sel;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        illegal_op;
  logic [31:0] retired_count;
  logic [3:0]  state;

  int          tests_run;
  int          tests_failed;
  logic [31:0] exp_count;

  mips_multicycle_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_en         (pc_en),
    .pc_src        (pc_src),
    .jump_sel      (jump_sel),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .illegal_op    (illegal_op),
    .retired_count (retired_count),
    .state         (state)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a broken run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Move to the observation point of the next cycle.
  task automatic advance();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'b000000;
    zero      = 1'b0;
    repeat (3) advance();
    tests_run++;
    if (state !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got %0d expected 0", state);
    end
    tests_run++;
    if ({mem_read, pc_en, ir_write, mem_write, reg_write, illegal_op} !== 6'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_strobes: got %b expected 000000",
               {mem_read, pc_en, ir_write, mem_write, reg_write, illegal_op});
    end
    tests_run++;
    if (retired_count !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_count: got %0h expected 0", retired_count);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if ({mem_read, pc_en, ir_write, alu_src_b} !== 5'b11101) begin
      tests_failed++;
      $display("[TB] FAIL release_fetch: got %b expected 11101",
               {mem_read, pc_en, ir_write, alu_src_b});
    end
    exp_count = 32'd0;
  endtask

  task automatic test_rtype();
    logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    opcode    = 6'b000000;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (state !== seq[i]) begin
        tests_failed++;
        $display("[TB] FAIL rtype_seq[%0d]: got %0d expected %0d", i, state, seq[i]);
      end
      if (i == 2) begin
        tests_run++;
        if ({alu_src_a, alu_src_b, alu_op} !== 5'b10010) begin
          tests_failed++;
          $display("[TB] FAIL rtype_exec_alu: got %b expected 10010",
                   {alu_src_a, alu_src_b, alu_op});
        end
      end
      if (i == 3) begin
        tests_run++;
        if ({reg_write, reg_dst, mem_to_reg} !== 3'b110) begin
          tests_failed++;
          $display("[TB] FAIL rtype_aluwb: got %b expected 110", {reg_write, reg_dst, mem_to_reg});
        end
        tests_run++;
        if (retired_count !== exp_count) begin
          tests_failed++;
          $display("[TB] FAIL rtype_count_before: got %0h expected %0h", retired_count, exp_count);
        end
      end
      if (i < 4) advance();
    end
    exp_count = exp_count + 32'd1;
    tests_run++;
    if (retired_count !== exp_count) begin
      tests_failed++;
      $display("[TB] FAIL rtype_count_after: got %0h expected %0h", retired_count, exp_count);
    end
  endtask

  task automatic test_lw_stall();
    logic [3:0] seq [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic       mr  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    opcode = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i];
      #1;
      tests_run++;
      if (state !== seq[i]) begin
        tests_failed++;
        $display("[TB] FAIL lw_seq[%0d]: got %0d expected %0d", i, state, seq[i]);
      end
      if (i == 3) begin
        tests_run++;
        if ({mem_read, iord, mem_write} !== 3'b110) begin
          tests_failed++;
          $display("[TB] FAIL lw_memrd: got %b expected 110", {mem_read, iord, mem_write});
        end
      end
      if (i == 6) begin
        tests_run++;
        if ({reg_write, mem_to_reg, reg_dst} !== 3'b110) begin
          tests_failed++;
          $display("[TB] FAIL lw_memwb: got %b expected 110", {reg_write, mem_to_reg, reg_dst});
        end
        tests_run++;
        if (retired_count !== exp_count) begin
          tests_failed++;
          $display("[TB] FAIL lw_count_before: got %0h expected %0h", retired_count, exp_count);
        end
      end
      if (i < 7) advance();
    end
    exp_count = exp_count + 32'd1;
    tests_run++;
    if (retired_count !== exp_count) begin
      tests_failed++;
      $display("[TB] FAIL lw_count_after: got %0h expected %0h", retired_count, exp_count);
    end
  endtask

  task automatic test_sw();
    logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    opcode    = 6'b101011;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (state !== seq[i]) begin
        tests_failed++;
        $display("[TB] FAIL sw_seq[%0d]: got %0d expected %0d", i, state, seq[i]);
      end
      if (i == 3) begin
        tests_run++;
        if ({mem_write, iord, mem_read, reg_write} !== 4'b1100) begin
          tests_failed++;
          $display("[TB] FAIL sw_memwr: got %b expected 1100",
                   {mem_write, iord, mem_read, reg_write});
        end
      end
      if (i < 4) advance();
    end
    exp_count = exp_count + 32'd1;
    tests_run++;
    if (retired_count !== exp_count) begin
      tests_failed++;
      $display("[TB] FAIL sw_count: got %0h expected %0h", retired_count, exp_count);
    end
  endtask

  task automatic test_beq();
    logic zv [2] = '{1'b1, 1'b0};
    opcode    = 6'b000100;
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      zero = zv[k];
      advance();
      advance();
      tests_run++;
      if (state !== 4'd8) begin
        tests_failed++;
        $display("[TB] FAIL beq_state[%0d]: got %0d expected 8", k, state);
      end
      tests_run++;
      if ({pc_en, pc_src, alu_op} !== {zv[k], 1'b1, 2'b01}) begin
        tests_failed++;
        $display("[TB] FAIL beq_pc[%0d]: got %b expected %b", k,
                 {pc_en, pc_src, alu_op}, {zv[k], 1'b1, 2'b01});
      end
      advance();
      exp_count = exp_count + 32'd1;
      tests_run++;
      if (state !== 4'd0 || retired_count !== exp_count) begin
        tests_failed++;
        $display("[TB] FAIL beq_retire[%0d]: got state %0d count %0h expected state 0 count %0h",
                 k, state, retired_count, exp_count);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal();
    opcode    = 6'b111111;
    mem_ready = 1'b1;
    tests_run++;
    if (illegal_op !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL illegal_fetch: got %b expected 0", illegal_op);
    end
    advance();
    tests_run++;
    if (state !== 4'd1 || illegal_op !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL illegal_decode: got state %0d pulse %b expected state 1 pulse 1",
               state, illegal_op);
    end
    advance();
    tests_run++;
    if (state !== 4'd0 || illegal_op !== 1'b0 || retired_count !== exp_count) begin
      tests_failed++;
      $display("[TB] FAIL illegal_return: got state %0d pulse %b count %0h expected 0 0 %0h",
               state, illegal_op, retired_count, exp_count);
    end
  endtask

  task automatic test_jump();
    opcode    = 6'b000010;
    mem_ready = 1'b1;
    advance();
    advance();
    tests_run++;
    if (state !== 4'd9 || {pc_en, jump_sel} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL jump: got state %0d pc_en/jump_sel %b expected 9 11",
               state, {pc_en, jump_sel});
    end
    advance();
    exp_count = exp_count + 32'd1;
    tests_run++;
    if (state !== 4'd0 || retired_count !== exp_count) begin
      tests_failed++;
      $display("[TB] FAIL jump_retire: got state %0d count %0h expected 0 %0h",
               state, retired_count, exp_count);
    end
  endtask

  task automatic test_addi();
    logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
    opcode    = 6'b001000;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (state !== seq[i]) begin
        tests_failed++;
        $display("[TB] FAIL addi_seq[%0d]: got %0d expected %0d", i, state, seq[i]);
      end
      if (i == 2) begin
        tests_run++;
        if ({alu_src_a, alu_src_b, alu_op} !== 5'b11000) begin
          tests_failed++;
          $display("[TB] FAIL addi_ex: got %b expected 11000", {alu_src_a, alu_src_b, alu_op});
        end
      end
      if (i == 3) begin
        tests_run++;
        if ({reg_write, reg_dst, mem_to_reg} !== 3'b100) begin
          tests_failed++;
          $display("[TB] FAIL addi_wb: got %b expected 100", {reg_write, reg_dst, mem_to_reg});
        end
      end
      if (i < 4) advance();
    end
    exp_count = exp_count + 32'd1;
    tests_run++;
    if (retired_count !== exp_count) begin
      tests_failed++;
      $display("[TB] FAIL addi_count: got %0h expected %0h", retired_count, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    opcode    = 6'b101011;
    mem_ready = 1'b1;
    advance();
    advance();
    advance();
    mem_ready = 1'b0;
    #1;
    tests_run++;
    if (state !== 4'd5 || mem_write !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_pre: got state %0d mem_write %b expected 5 1", state, mem_write);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (state !== 4'd0 || mem_write !== 1'b0 || retired_count !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_now: got state %0d mem_write %b count %0h expected 0 0 0",
               state, mem_write, retired_count);
    end
    advance();
    tests_run++;
    if (state !== 4'd0 || {mem_write, mem_read, reg_write} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL midreset_hold: got state %0d strobes %b expected 0 000",
               state, {mem_write, mem_read, reg_write});
    end
    mem_ready = 1'b1;
    rst_n     = 1'b1;
    #1;
    exp_count = 32'd0;
  endtask

  task automatic test_wrap();
    force dut.retired_count = 32'hFFFF_FFFF;
    #1;
    release dut.retired_count;
    exp_count = 32'hFFFF_FFFF;
    tests_run++;
    if (retired_count !== exp_count) begin
      tests_failed++;
      $display("[TB] FAIL wrap_preload: got %0h expected %0h", retired_count, exp_count);
    end
    opcode    = 6'b000000;
    mem_ready = 1'b1;
    advance();
    advance();
    advance();
    advance();
    tests_run++;
    if (state !== 4'd0 || retired_count !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL wrap: got state %0d count %0h expected 0 0", state, retired_count);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_count    = 32'd0;
    rst_n        = 1'b0;
    opcode       = 6'b000000;
    zero         = 1'b0;
    mem_ready    = 1'b1;

    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw();
    test_beq();
    test_illegal();
    test_jump();
    test_addi();
    test_reset_mid();
    test_wrap();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
